xy_zone_tracker: RTL and testbench

Registered, parametrised successor to the combinational XY-to-LED zone indicator. It classifies tracked IR-blob coordinates into five zones: centre, right, left, down and up. It adds per-zone hysteresis, a consecutive-sample debounce and a lost-tracking timeout that blinks all LEDs. It sits between the camera coordinate decoder, which supplies x/y plus a valid strobe, and the board LEDs, and is used as an aiming aid.

---
 rtl/xy_zone_pkg.sv | 32 +++
 rtl/xy_zone_classify.sv | 63 ++++++
 rtl/xy_zone_tracker.sv | 143 ++++++++++++++
 tb/tb_xy_zone_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xy_zone_pkg.sv
// Shared definitions for the XY zone tracker and its classifier.
// Holds zone bit indices, the camera no-blob code and threshold arithmetic.
// Pure constants and constant functions; no logic is generated here.
package xy_zone_pkg;

  localparam int NZ         = 5;
  localparam int ZB_CENTRE  = 0;
  localparam int ZB_RIGHT   = 1;
  localparam int ZB_LEFT    = 2;
  localparam int ZB_DOWN    = 3;
  localparam int ZB_UP      = 4;

  // Coordinate value the camera reports when it sees no blob.
  function automatic int all_ones(input int w);
    return (1 << w) - 1;
  endfunction

  // Threshold around a midpoint. 'delta' widens the band outward
  // (positive) or shrinks it inward (negative); 'upper' selects which side.
  function automatic int zone_thr(input int mid, input int cent_d,
                                  input int delta, input bit upper);
    return upper ? (mid + cent_d + delta) : (mid - cent_d - delta);
  endfunction

  // True when every threshold of one axis stays strictly inside the
  // representable range, excluding the no-blob code.
  function automatic bit axis_ok(input int mid, input int cent_d,
                                 input int hyst, input int w);
    return (mid - cent_d - hyst > 0) && (mid + cent_d + hyst < all_ones(w));
  endfunction

endpackage

// File: rtl/xy_zone_classify.sv
// Classifies one coordinate pair into a raw five-bit zone mask.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Ports: x, y coordinates; mask_q currently displayed mask (selects
// hysteresis per zone); raw classified mask (bit0 centre .. bit4 up).
module xy_zone_classify
  import xy_zone_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int MID_X   = 500,
  parameter int MID_Y   = 500,
  parameter int CENT_D  = 250,
  parameter int HYST    = 16
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [NZ-1:0]      mask_q,
  output logic [NZ-1:0]      raw
);

  localparam int TW = COORD_W + 1;

  // Nominal, shrunk (edge already lit) and widened (centre already lit)
  // thresholds for each side of each axis.
  localparam logic [TW-1:0] X_HI_N   = TW'(zone_thr(MID_X, CENT_D, 0, 1'b1));
  localparam logic [TW-1:0] X_HI_IN  = TW'(zone_thr(MID_X, CENT_D, -HYST, 1'b1));
  localparam logic [TW-1:0] X_HI_OUT = TW'(zone_thr(MID_X, CENT_D, HYST, 1'b1));
  localparam logic [TW-1:0] X_LO_N   = TW'(zone_thr(MID_X, CENT_D, 0, 1'b0));
  localparam logic [TW-1:0] X_LO_IN  = TW'(zone_thr(MID_X, CENT_D, -HYST, 1'b0));
  localparam logic [TW-1:0] X_LO_OUT = TW'(zone_thr(MID_X, CENT_D, HYST, 1'b0));
  localparam logic [TW-1:0] Y_HI_N   = TW'(zone_thr(MID_Y, CENT_D, 0, 1'b1));
  localparam logic [TW-1:0] Y_HI_IN  = TW'(zone_thr(MID_Y, CENT_D, -HYST, 1'b1));
  localparam logic [TW-1:0] Y_HI_OUT = TW'(zone_thr(MID_Y, CENT_D, HYST, 1'b1));
  localparam logic [TW-1:0] Y_LO_N   = TW'(zone_thr(MID_Y, CENT_D, 0, 1'b0));
  localparam logic [TW-1:0] Y_LO_IN  = TW'(zone_thr(MID_Y, CENT_D, -HYST, 1'b0));
  localparam logic [TW-1:0] Y_LO_OUT = TW'(zone_thr(MID_Y, CENT_D, HYST, 1'b0));

  if (!axis_ok(MID_X, CENT_D, HYST, COORD_W) ||
      !axis_ok(MID_Y, CENT_D, HYST, COORD_W)) begin : g_bad_params
    $error("xy_zone_classify: thresholds fall outside the coordinate range");
  end

  logic [TW-1:0] xe, ye;
  logic [TW-1:0] cx_lo, cx_hi, cy_lo, cy_hi;

  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y};
    // A lit centre box grows by HYST on every side.
    cx_lo = mask_q[ZB_CENTRE] ? X_LO_OUT : X_LO_N;
    cx_hi = mask_q[ZB_CENTRE] ? X_HI_OUT : X_HI_N;
    cy_lo = mask_q[ZB_CENTRE] ? Y_LO_OUT : Y_LO_N;
    cy_hi = mask_q[ZB_CENTRE] ? Y_HI_OUT : Y_HI_N;

    raw            = '0;
    raw[ZB_CENTRE] = (xe > cx_lo) && (xe < cx_hi) && (ye > cy_lo) && (ye < cy_hi);
    // A lit edge zone moves its threshold HYST toward the centre.
    raw[ZB_RIGHT]  = xe > (mask_q[ZB_RIGHT] ? X_HI_IN : X_HI_N);
    raw[ZB_LEFT]   = xe < (mask_q[ZB_LEFT]  ? X_LO_IN : X_LO_N);
    raw[ZB_DOWN]   = ye > (mask_q[ZB_DOWN]  ? Y_HI_IN : Y_HI_N);
    raw[ZB_UP]     = ye < (mask_q[ZB_UP]    ? Y_LO_IN : Y_LO_N);
  end

endmodule

// File: rtl/xy_zone_tracker.sv
// Debounced, hysteretic XY-to-LED zone indicator with lost-tracking blink.
// Latency: leds/zone_change update one clk after the deciding sample.
// Backpressure: none; every xy_valid strobe is consumed in its cycle.
// Ports: clk, reset_n (sync, active-low); x, y, xy_valid from the camera
// decoder; leds (bit0 centre, 1 right, 2 left, 3 down, 4 up);
// zone_change one-cycle pulse on display change; lost while untracked.
module xy_zone_tracker
  import xy_zone_pkg::*;
#(
  parameter int COORD_W   = 11,
  parameter int MID_X     = 500,
  parameter int MID_Y     = 500,
  parameter int CENT_D    = 250,
  parameter int HYST      = 16,
  parameter int HOLD      = 3,
  parameter int TIMEOUT   = 2_000_000,
  parameter int BLINK_DIV = 6_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               xy_valid,
  output logic [NZ-1:0]      leds,
  output logic               zone_change,
  output logic               lost
);

  localparam int CNT_W = $clog2(HOLD + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  localparam logic [COORD_W-1:0] NOBLOB   = COORD_W'(all_ones(COORD_W));
  localparam logic [CNT_W-1:0]   HOLD_C   = CNT_W'(HOLD);
  localparam logic [TMO_W-1:0]   TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [NZ-1:0]    mask_q, mask_d;
  logic [NZ-1:0]    cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [TMO_W-1:0] tmo_cnt, tmo_d;
  logic [BLK_W-1:0] blink_cnt, bcnt_d;
  logic             blink, blink_d;
  logic             lost_d, zc_d;
  logic             good;
  logic [NZ-1:0]    raw;

  xy_zone_classify #(
    .COORD_W (COORD_W),
    .MID_X   (MID_X),
    .MID_Y   (MID_Y),
    .CENT_D  (CENT_D),
    .HYST    (HYST)
  ) u_classify (
    .x      (x),
    .y      (y),
    .mask_q (mask_q),
    .raw    (raw)
  );

  assign good = xy_valid && (x != NOBLOB) && (y != NOBLOB);

  always_comb begin
    mask_d  = mask_q;
    cand_d  = cand;
    cnt_d   = cnt;
    cnt_inc = cnt;
    tmo_d   = tmo_cnt;
    lost_d  = lost;
    zc_d    = 1'b0;
    bcnt_d  = blink_cnt;
    blink_d = blink;

    if (good) begin
      if (raw == cand) begin
        cnt_inc = (cnt == HOLD_C) ? cnt : cnt + CNT_W'(1);
      end else begin
        cnt_inc = CNT_W'(1);
      end
      cand_d = raw;
      cnt_d  = cnt_inc;
      if ((cnt_inc == HOLD_C) && (raw != mask_q)) begin
        mask_d = raw;
        zc_d   = 1'b1;
      end
      // A good sample always beats a coincident timeout expiry.
      tmo_d  = '0;
      lost_d = 1'b0;
    end else begin
      if (xy_valid) begin
        cnt_d = '0;
      end
      tmo_d = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
      if (tmo_d == TMO_MAX) begin
        lost_d = 1'b1;
        mask_d = '0;
        cnt_d  = '0;
        zc_d   = (mask_q != '0);
      end
    end

    // The blink divider only runs while lost stays high; it starts from a
    // dark phase each time tracking is lost.
    if (lost && lost_d) begin
      if (blink_cnt == BLK_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink;
      end else begin
        bcnt_d = blink_cnt + BLK_W'(1);
      end
    end else begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end
  end

  // leds are built from next-state values so the display moves on the
  // same edge that commits the new mask.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q      <= '0;
      cand        <= '0;
      cnt         <= '0;
      tmo_cnt     <= '0;
      lost        <= 1'b1;
      blink       <= 1'b0;
      blink_cnt   <= '0;
      leds        <= '0;
      zone_change <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      cand        <= cand_d;
      cnt         <= cnt_d;
      tmo_cnt     <= tmo_d;
      lost        <= lost_d;
      blink       <= blink_d;
      blink_cnt   <= bcnt_d;
      leds        <= lost_d ? {NZ{blink_d}} : mask_d;
      zone_change <= zc_d;
    end
  end

endmodule

// File: tb/tb_xy_zone_tracker.sv
module tb_xy_zone_tracker;

  localparam int COORD_W   = 11;
  localparam int MID       = 500;
  localparam int CD        = 250;
  localparam int HYST      = 16;
  localparam int HOLD      = 3;
  localparam int TIMEOUT   = 100;
  localparam int BLINK_DIV = 10;
  localparam int NOBLOB    = 2047;

  logic               clk;
  logic               reset_n;
  logic [COORD_W-1:0] x, y;
  logic               xy_valid;
  logic [4:0]         leds;
  logic               zone_change;
  logic               lost;

  int checks   = 0;
  int failures = 0;
  int zc_seen  = 0;

  xy_zone_tracker #(
    .COORD_W   (COORD_W),
    .MID_X     (MID),
    .MID_Y     (MID),
    .CENT_D    (CD),
    .HYST      (HYST),
    .HOLD      (HOLD),
    .TIMEOUT   (TIMEOUT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .y           (y),
    .xy_valid    (xy_valid),
    .leds        (leds),
    .zone_change (zone_change),
    .lost        (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Zone classification written straight from the threshold rules.
  function automatic int classify(input int xi, input int yi, input int m);
    int r = 0;
    int hc = (m & 1) ? HYST : 0;
    if (xi > MID - (CD + hc) && xi < MID + (CD + hc) &&
        yi > MID - (CD + hc) && yi < MID + (CD + hc)) r |= 1;
    if (xi > MID + CD - (((m >> 1) & 1) ? HYST : 0)) r |= 2;
    if (xi < MID - CD + (((m >> 2) & 1) ? HYST : 0)) r |= 4;
    if (yi > MID + CD - (((m >> 3) & 1) ? HYST : 0)) r |= 8;
    if (yi < MID - CD + (((m >> 4) & 1) ? HYST : 0)) r |= 16;
    return r;
  endfunction

  // Behavioural model: displayed mask, current run of identical raw masks,
  // cycles since the last good sample, and how long tracking has been lost
  // (blink phase = parity of lost_age / BLINK_DIV).
  int m_mask, m_cand, m_run, m_idle, m_age;
  bit m_lost, started;
  int e_leds, e_zc;

  always @(posedge clk) begin
    bit good, prev_lost;
    int raw;
    if (!reset_n) begin
      m_mask = 0; m_cand = 0; m_run = 0; m_idle = 0; m_age = 0;
      m_lost = 1; e_leds = 0; e_zc = 0; started = 1;
    end else if (started) begin
      good = xy_valid && (int'(x) != NOBLOB) && (int'(y) != NOBLOB);
      prev_lost = m_lost;
      e_zc = 0;
      if (good) begin
        raw = classify(int'(x), int'(y), m_mask);
        if (raw == m_cand) m_run = (m_run < HOLD) ? m_run + 1 : HOLD;
        else begin m_cand = raw; m_run = 1; end
        if (m_run == HOLD && raw != m_mask) begin m_mask = raw; e_zc = 1; end
        m_idle = 0;
        m_lost = 0;
      end else begin
        if (xy_valid) m_run = 0;
        if (m_idle < TIMEOUT) m_idle++;
        if (m_idle == TIMEOUT) begin
          if (m_mask != 0) e_zc = 1;
          m_mask = 0; m_run = 0; m_lost = 1;
        end
      end
      m_age = (m_lost && prev_lost) ? m_age + 1 : 0;
      e_leds = m_lost ? ((((m_age / BLINK_DIV) % 2) == 1) ? 31 : 0) : m_mask;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_leds", int'(leds), e_leds);
      check("model_zone_change", int'(zone_change), e_zc);
      check("model_lost", int'(lost), int'(m_lost));
    end
  end

  task automatic strobe(input int xi, input int yi);
    x = COORD_W'(xi);
    y = COORD_W'(yi);
    xy_valid = 1'b1;
    @(posedge clk); #1;
    xy_valid = 1'b0;
    zc_seen += int'(zone_change);
  endtask

  task automatic strobes(input int xi, input int yi, input int n);
    for (int i = 0; i < n; i++) strobe(xi, yi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      zc_seen += int'(zone_change);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; xy_valid = 1'b0; x = '0; y = '0;
    @(posedge clk); #1;
    do_reset();

    // 1: reset state and first lock onto centre
    check("rst_leds", int'(leds), 0);
    check("rst_lost", int'(lost), 1);
    check("rst_zc", int'(zone_change), 0);
    strobe(500, 500);
    check("t1_lost_cleared", int'(lost), 0);
    check("t1_leds_s1", int'(leds), 0);
    strobe(500, 500);
    check("t1_leds_s2", int'(leds), 0);
    strobe(500, 500);
    check("t1_leds_s3", int'(leds), 5'b00001);
    check("t1_zc_pulse", int'(zone_change), 1);
    idle(1);
    check("t1_zc_single", int'(zone_change), 0);

    // 2: centre hysteresis keeps centre lit, right hysteresis holds right
    strobes(760, 500, 3);
    check("t2_760", int'(leds), 5'b00011);
    check("t2_760_zc", int'(zone_change), 1);
    strobes(740, 500, 3);
    check("t2_740", int'(leds), 5'b00011);
    check("t2_740_zc", int'(zone_change), 0);
    strobes(730, 500, 3);
    check("t2_730", int'(leds), 5'b00001);

    // 3: a value exactly on a threshold lights nothing
    do_reset();
    zc_seen = 0;
    strobes(750, 500, 3);
    check("t3_leds", int'(leds), 0);
    check("t3_no_zc", zc_seen, 0);

    // 4: a differing sample restarts the debounce run
    do_reset();
    zc_seen = 0;
    strobes(900, 500, 2);
    strobe(500, 500);
    strobes(900, 500, 2);
    check("t4_before_third", int'(leds), 0);
    strobe(900, 500);
    check("t4_after_third", int'(leds), 5'b00010);
    check("t4_one_pulse", zc_seen, 1);

    // 5: timeout, blinking, no-blob samples, recovery
    idle(TIMEOUT - 1);
    check("t5_not_yet_lost", int'(lost), 0);
    check("t5_leds_held", int'(leds), 5'b00010);
    idle(1);
    check("t5_lost", int'(lost), 1);
    check("t5_dark", int'(leds), 0);
    check("t5_loss_zc", int'(zone_change), 1);
    idle(BLINK_DIV - 1);
    check("t5_still_dark", int'(leds), 0);
    idle(1);
    check("t5_blink_on", int'(leds), 5'b11111);
    idle(BLINK_DIV);
    check("t5_blink_off", int'(leds), 0);
    strobes(NOBLOB, NOBLOB, 3);
    check("t5_noblob_lost", int'(lost), 1);
    strobe(500, 500);
    check("t5_recovered", int'(lost), 0);
    check("t5_mask_cleared", int'(leds), 0);

    // 6: reset in the middle of a debounce run
    strobes(900, 500, 3);
    check("t6_right", int'(leds), 5'b00010);
    strobes(500, 500, 2);
    do_reset();
    check("t6_rst_leds", int'(leds), 0);
    check("t6_rst_lost", int'(lost), 1);
    check("t6_rst_zc", int'(zone_change), 0);
    strobes(500, 500, 2);
    check("t6_two_after_rst", int'(leds), 0);
    strobe(500, 500);
    check("t6_third_after_rst", int'(leds), 5'b00001);

    // no-blob sample breaks a run without touching the display
    strobes(900, 500, 2);
    strobe(NOBLOB, 500);
    strobes(900, 500, 2);
    check("nb_run_broken", int'(leds), 5'b00001);
    strobe(900, 500);
    check("nb_run_done", int'(leds), 5'b00010);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
